// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int BeatCntWidth = 16;

    function automatic logic [BeatCntWidth-1:0] sat_inc(input logic [BeatCntWidth-1:0] v);
        return (&v) ? v : v + BeatCntWidth'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_i, wrapping modulo NumIn.
module rr_pick #(
    parameter int NumIn    = 4,
    parameter int IdxWidth = $clog2(NumIn)
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [IdxWidth-1:0] rr_i,
    output logic [IdxWidth-1:0] winner_o,
    output logic                any_o
);
    localparam int PtrWidth = IdxWidth + 1;
    localparam logic [PtrWidth-1:0] NumInP = PtrWidth'(NumIn);

    logic [NumIn-1:0]    rot;
    logic [NumIn-1:0]    rot_rev;
    logic [IdxWidth-1:0] lzc;
    logic                found;

    // Sums never exceed 2*NumIn-1, so a single conditional subtract is a full modulo.
    function automatic logic [IdxWidth-1:0] wrap(input logic [PtrWidth-1:0] p);
        logic [PtrWidth-1:0] r;
        r = (p >= NumInP) ? p - NumInP : p;
        return r[IdxWidth-1:0];
    endfunction

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_rot
        assign rot[gi]               = req_i[wrap({1'b0, rr_i} + PtrWidth'(gi + 1))];
        assign rot_rev[NumIn-1-gi]   = rot[gi];
    end

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            if (!found && rot_rev[NumIn-1-k]) begin
                lzc   = IdxWidth'(k);
                found = 1'b1;
            end
        end
    end

    assign winner_o = found ? wrap({1'b0, rr_i} + {1'b0, lzc} + PtrWidth'(1)) : '0;
    assign any_o    = |req_i;

endmodule

// File: rtl/stream_rr_burst_arbiter.sv
// Round-robin valid/ready arbiter with packet lock and optional burst cap.
// Define STREAM_ARB_BEAT_STATS_EN to add per-input saturating transfer counters (beat_cnt_o).
module stream_rr_burst_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 0,
    parameter int IdxWidth  = $clog2(NumIn)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clr_i,
    input  logic [NumIn-1:0][DataWidth-1:0] inp_data_i,
    input  logic [NumIn-1:0]                inp_last_i,
    input  logic [NumIn-1:0]                inp_valid_i,
    output logic [NumIn-1:0]                inp_ready_o,
    output logic [DataWidth-1:0]            oup_data_o,
    output logic                            oup_last_o,
    output logic [IdxWidth-1:0]             oup_idx_o,
    output logic                            oup_valid_o,
    input  logic                            oup_ready_i
`ifdef STREAM_ARB_BEAT_STATS_EN
    ,
    output logic [NumIn-1:0][BeatCntWidth-1:0] beat_cnt_o
`endif
);
    localparam int BeatWidth = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
    localparam logic [IdxWidth-1:0] RrInit = IdxWidth'(NumIn - 1);

    arb_state_e           st_q, st_d;
    logic [IdxWidth-1:0]  rr_q, rr_d;
    logic [IdxWidth-1:0]  lock_q, lock_d;
    logic [BeatWidth-1:0] beat_q, beat_d;

    logic [IdxWidth-1:0]  pick_idx;
    logic                 pick_any;
    logic [IdxWidth-1:0]  win;
    logic                 win_valid;
    logic                 blocked;
    logic                 fire;
    logic                 burst_done;
    logic [BeatWidth-1:0] beat_inc;

    rr_pick #(
        .NumIn    (NumIn),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req_i    (inp_valid_i),
        .rr_i     (rr_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    // With MaxBurst=0 the beat counter never leaves zero and never forces a release.
    assign burst_done = (MaxBurst > 0) && (beat_q == BeatWidth'(MaxBurst - 1));
    assign beat_inc   = (MaxBurst > 0) ? beat_q + BeatWidth'(1) : '0;

    always_comb begin
        blocked = rst_i | clr_i;
        if (st_q == LOCKED) begin
            win       = lock_q;
            win_valid = inp_valid_i[lock_q];
        end else begin
            win       = pick_idx;
            win_valid = pick_any;
        end

        oup_valid_o      = win_valid & ~blocked;
        oup_data_o       = win_valid ? inp_data_i[win] : '0;
        oup_last_o       = win_valid & inp_last_i[win];
        oup_idx_o        = win_valid ? win : '0;
        inp_ready_o      = '0;
        inp_ready_o[win] = oup_ready_i & win_valid & ~blocked;
        fire             = oup_valid_o & oup_ready_i;

        st_d   = st_q;
        rr_d   = rr_q;
        lock_d = lock_q;
        beat_d = beat_q;
        if (fire) begin
            if (inp_last_i[win] || burst_done) begin
                st_d   = IDLE;
                rr_d   = win;
                beat_d = '0;
            end else begin
                st_d   = LOCKED;
                lock_d = win;
                beat_d = beat_inc;
            end
        end else if (oup_valid_o && st_q == IDLE) begin
            // Freeze the selection while the consumer stalls.
            st_d   = LOCKED;
            lock_d = win;
        end

        if (clr_i) begin
            st_d   = IDLE;
            rr_d   = RrInit;
            lock_d = '0;
            beat_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= IDLE;
            rr_q   <= RrInit;
            lock_q <= '0;
            beat_q <= '0;
        end else begin
            st_q   <= st_d;
            rr_q   <= rr_d;
            lock_q <= lock_d;
            beat_q <= beat_d;
        end
    end

`ifdef STREAM_ARB_BEAT_STATS_EN
    for (genvar gi = 0; gi < NumIn; gi++) begin : g_stats
        logic [BeatCntWidth-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (fire && win == IdxWidth'(gi)) begin
                cnt_d = sat_inc(cnt_q);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign beat_cnt_o[gi] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_stream_rr_burst_arbiter.sv
// Scoreboard bench: dut 0 runs unlimited bursts, dut 1 runs MaxBurst=2.
module tb_stream_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    logic [N-1:0][DW-1:0] inp_data  [2];
    logic [N-1:0]         inp_last  [2];
    logic [N-1:0]         inp_valid [2];
    logic [N-1:0]         inp_ready [2];
    logic [DW-1:0]        oup_data  [2];
    logic                 oup_last  [2];
    logic [1:0]           oup_idx   [2];
    logic                 oup_valid [2];
    logic                 oup_ready [2];
    logic [N-1:0]         fire      [2];
`ifdef STREAM_ARB_BEAT_STATS_EN
    logic [N-1:0][15:0]   beat_cnt  [2];
`endif

    logic [DW:0] src_q [2*N][$];
    beat_t       exp_q [2][$];
    int          checks = 0;
    int          errors = 0;
    bit          quiet  = 1'b0;

    stream_rr_burst_arbiter #(.NumIn(N), .DataWidth(DW), .MaxBurst(0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .inp_data_i  (inp_data[0]),
        .inp_last_i  (inp_last[0]),
        .inp_valid_i (inp_valid[0]),
        .inp_ready_o (inp_ready[0]),
        .oup_data_o  (oup_data[0]),
        .oup_last_o  (oup_last[0]),
        .oup_idx_o   (oup_idx[0]),
        .oup_valid_o (oup_valid[0]),
        .oup_ready_i (oup_ready[0])
`ifdef STREAM_ARB_BEAT_STATS_EN
        ,
        .beat_cnt_o  (beat_cnt[0])
`endif
    );

    stream_rr_burst_arbiter #(.NumIn(N), .DataWidth(DW), .MaxBurst(2)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .inp_data_i  (inp_data[1]),
        .inp_last_i  (inp_last[1]),
        .inp_valid_i (inp_valid[1]),
        .inp_ready_o (inp_ready[1]),
        .oup_data_o  (oup_data[1]),
        .oup_last_o  (oup_last[1]),
        .oup_idx_o   (oup_idx[1]),
        .oup_valid_o (oup_valid[1]),
        .oup_ready_i (oup_ready[1])
`ifdef STREAM_ARB_BEAT_STATS_EN
        ,
        .beat_cnt_o  (beat_cnt[1])
`endif
    );

    task automatic put(input int d, input int i, input logic [DW-1:0] data, input logic last);
        src_q[d*N+i].push_back({last, data});
    endtask

    task automatic expect_beat(input int d, input int i, input logic [DW-1:0] data, input logic last);
        beat_t e;
        e.idx  = 2'(i);
        e.data = data;
        e.last = last;
        exp_q[d].push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit all_idle();
        bit ok = 1'b1;
        for (int k = 0; k < 2*N; k++) if (src_q[k].size() != 0) ok = 1'b0;
        for (int d = 0; d < 2; d++) if (exp_q[d].size() != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL %s drain timeout: pending exp0=%0d exp1=%0d, required 0", name,
                     exp_q[0].size(), exp_q[1].size());
        end
    endtask

    // Source models: present the head of each queue, pop on an observed handshake.
    initial begin
        for (int d = 0; d < 2; d++) begin
            inp_valid[d] = '0;
            inp_last[d]  = '0;
            inp_data[d]  = '0;
            fire[d]      = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (fire[d][i] && src_q[d*N+i].size() > 0) void'(src_q[d*N+i].pop_front());
                    if (src_q[d*N+i].size() > 0) begin
                        inp_valid[d][i] = 1'b1;
                        inp_data[d][i]  = src_q[d*N+i][0][DW-1:0];
                        inp_last[d][i]  = src_q[d*N+i][0][DW];
                    end else begin
                        inp_valid[d][i] = 1'b0;
                        inp_data[d][i]  = '0;
                        inp_last[d][i]  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every output handshake is checked against the head of the expected queue.
    initial begin
        beat_t        e;
        logic [N-1:0] one_hot;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                fire[d] = inp_valid[d] & inp_ready[d];
                if (oup_valid[d] && oup_ready[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL xfer dut%0d unexpected: idx=%0d data=%h, required no transfer",
                                 d, oup_idx[d], oup_data[d]);
                    end else begin
                        e       = exp_q[d].pop_front();
                        one_hot = 4'b0001 << e.idx;
                        if (oup_idx[d] !== e.idx || oup_data[d] !== e.data ||
                            oup_last[d] !== e.last || inp_ready[d] !== one_hot) begin
                            errors++;
                            $display("FAIL xfer dut%0d: idx=%0d data=%h last=%0d rdy=%b, required idx=%0d data=%h last=%0d rdy=%b",
                                     d, oup_idx[d], oup_data[d], oup_last[d], inp_ready[d],
                                     e.idx, e.data, e.last, one_hot);
                        end else if (!quiet) begin
                            $display("xfer dut%0d idx=%0d data=%h last=%0d", d, oup_idx[d], oup_data[d], oup_last[d]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        clr          = 1'b0;
        oup_ready[0] = 1'b0;
        oup_ready[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        chk("reset_valid", 64'(oup_valid[0]), 64'd0);
        chk("reset_data",  64'(oup_data[0]),  64'd0);
        chk("reset_idx",   64'(oup_idx[0]),   64'd0);
        chk("reset_last",  64'(oup_last[0]),  64'd0);
        chk("reset_ready", 64'(inp_ready[0]), 64'd0);

        // Single-beat packets on every input, two on input 0: order 0,1,2,3,0
        put(0, 0, 32'h0000_0001, 1'b1);
        put(0, 0, 32'h0000_0002, 1'b1);
        put(0, 1, 32'h0001_0001, 1'b1);
        put(0, 2, 32'h0002_0001, 1'b1);
        put(0, 3, 32'h0003_0001, 1'b1);
        expect_beat(0, 0, 32'h0000_0001, 1'b1);
        expect_beat(0, 1, 32'h0001_0001, 1'b1);
        expect_beat(0, 2, 32'h0002_0001, 1'b1);
        expect_beat(0, 3, 32'h0003_0001, 1'b1);
        expect_beat(0, 0, 32'h0000_0002, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t1_rr", 50);
        oup_ready[0] = 1'b0;

        // 3-beat packet on input 1 holds off input 2 (rr=0)
        put(0, 1, 32'h0011_0001, 1'b0);
        put(0, 1, 32'h0011_0002, 1'b0);
        put(0, 1, 32'h0011_0003, 1'b1);
        put(0, 2, 32'h0012_0001, 1'b1);
        expect_beat(0, 1, 32'h0011_0001, 1'b0);
        expect_beat(0, 1, 32'h0011_0002, 1'b0);
        expect_beat(0, 1, 32'h0011_0003, 1'b1);
        expect_beat(0, 2, 32'h0012_0001, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t2_lock", 50);
        oup_ready[0] = 1'b0;

        // Stall with inputs 0 and 2 valid (rr=2): selection must stay on 0
        put(0, 0, 32'h0020_00AA, 1'b1);
        put(0, 2, 32'h0022_00BB, 1'b1);
        @(posedge clk); #2;
        for (int c = 0; c < 4; c++) begin
            chk("t4_stall_valid", 64'(oup_valid[0]), 64'd1);
            chk("t4_stall_idx",   64'(oup_idx[0]),   64'd0);
            chk("t4_stall_data",  64'(oup_data[0]),  64'h0020_00AA);
            @(posedge clk); #2;
        end
        expect_beat(0, 0, 32'h0020_00AA, 1'b1);
        expect_beat(0, 2, 32'h0022_00BB, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t4_stall", 50);
        oup_ready[0] = 1'b0;

        // MaxBurst=2: 5-beat packet on 0 interleaved with input 3 -> 0,0,3,0,0,3,0
        for (int b = 0; b < 5; b++) put(1, 0, 32'h0030_0000 + 32'(b), (b == 4) ? 1'b1 : 1'b0);
        put(1, 3, 32'h0033_0001, 1'b1);
        put(1, 3, 32'h0033_0002, 1'b1);
        expect_beat(1, 0, 32'h0030_0000, 1'b0);
        expect_beat(1, 0, 32'h0030_0001, 1'b0);
        expect_beat(1, 3, 32'h0033_0001, 1'b1);
        expect_beat(1, 0, 32'h0030_0002, 1'b0);
        expect_beat(1, 0, 32'h0030_0003, 1'b0);
        expect_beat(1, 3, 32'h0033_0002, 1'b1);
        expect_beat(1, 0, 32'h0030_0004, 1'b1);
        oup_ready[1] = 1'b1;
        drain("t3_burst", 50);
        oup_ready[1] = 1'b0;

        // Async reset while locked on input 2 mid-packet (rr=2 beforehand)
        put(0, 2, 32'h0042_0001, 1'b0);
        put(0, 2, 32'h0042_0002, 1'b0);
        put(0, 2, 32'h0042_0003, 1'b1);
        expect_beat(0, 2, 32'h0042_0001, 1'b0);
        @(posedge clk); #2 oup_ready[0] = 1'b1;
        @(posedge clk); #2 oup_ready[0] = 1'b0;
        chk("t5_locked_valid", 64'(oup_valid[0]), 64'd1);
        chk("t5_locked_idx",   64'(oup_idx[0]),   64'd2);
        chk("t5_locked_data",  64'(oup_data[0]),  64'h0042_0002);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(oup_valid[0]), 64'd0);
        chk("t5_rst_ready", 64'(inp_ready[0]), 64'd0);
        src_q[2].delete();
        @(posedge clk); #2 rst = 1'b0;
        put(0, 0, 32'h0050_0001, 1'b1);
        put(0, 3, 32'h0053_0001, 1'b1);
        expect_beat(0, 0, 32'h0050_0001, 1'b1);
        expect_beat(0, 3, 32'h0053_0001, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t5_after_rst", 50);
        oup_ready[0] = 1'b0;

        // Move rr to 0, lock on input 2, then synchronous clear
        put(0, 0, 32'h0060_0001, 1'b1);
        expect_beat(0, 0, 32'h0060_0001, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t5_rr0", 50);
        oup_ready[0] = 1'b0;
        put(0, 2, 32'h0062_0001, 1'b0);
        put(0, 2, 32'h0062_0002, 1'b1);
        expect_beat(0, 2, 32'h0062_0001, 1'b0);
        @(posedge clk); #2 oup_ready[0] = 1'b1;
        @(posedge clk); #2 oup_ready[0] = 1'b0;
        chk("t5_locked2_idx", 64'(oup_idx[0]), 64'd2);
        clr = 1'b1;
        #1;
        chk("t5_clr_valid", 64'(oup_valid[0]), 64'd0);
        chk("t5_clr_ready", 64'(inp_ready[0]), 64'd0);
        src_q[2].delete();
        @(posedge clk); #2 clr = 1'b0;
        put(0, 0, 32'h0070_0001, 1'b1);
        put(0, 3, 32'h0073_0001, 1'b1);
        expect_beat(0, 0, 32'h0070_0001, 1'b1);
        expect_beat(0, 3, 32'h0073_0001, 1'b1);
        oup_ready[0] = 1'b1;
        drain("t5_after_clr", 50);
        oup_ready[0] = 1'b0;

`ifdef STREAM_ARB_BEAT_STATS_EN
        clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
        for (int i = 0; i < N; i++) chk("t6_cnt_start", 64'(beat_cnt[0][i]), 64'd0);
        quiet = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            put(0, 1, 32'(k), 1'b1);
            expect_beat(0, 1, 32'(k), 1'b1);
        end
        $display("bulk: 70000 single-beat transfers queued on input 1");
        oup_ready[0] = 1'b1;
        drain("t6_bulk", 72000);
        oup_ready[0] = 1'b0;
        quiet = 1'b0;
        chk("t6_cnt0_zero", 64'(beat_cnt[0][0]), 64'd0);
        chk("t6_cnt1_sat",  64'(beat_cnt[0][1]), 64'hFFFF);
        chk("t6_cnt2_zero", 64'(beat_cnt[0][2]), 64'd0);
        chk("t6_cnt3_zero", 64'(beat_cnt[0][3]), 64'd0);
        clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
        for (int i = 0; i < N; i++) chk("t6_cnt_clr", 64'(beat_cnt[0][i]), 64'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
